// File: rtl/whiz_line_renderer.sv
// Background scanline renderer: fetches map/tile bytes over one VRAM port and streams shaded pixels.
// Optional window layer is compiled in with `define WHIZ_WINDOW_EN.
module whiz_line_renderer #(
  parameter int LINE_W     = 160,
  parameter int MAP_DIM    = 32,
  parameter int BPP        = 2,
  parameter int SHADE_W    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int VRAM_AW    = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          drawline,
  input  logic [7:0]                    line_y,
  input  logic [7:0]                    scroll_x,
  input  logic [7:0]                    scroll_y,
  input  logic [(1<<BPP)*SHADE_W-1:0]   palette,
  input  logic [VRAM_AW-1:0]            map_base,
  input  logic [VRAM_AW-1:0]            tile_base,
`ifdef WHIZ_WINDOW_EN
  input  logic                          win_en,
  input  logic [7:0]                    win_x,
  input  logic [7:0]                    win_y,
  input  logic [VRAM_AW-1:0]            win_map_base,
`endif
  output logic                          vram_req,
  output logic [VRAM_AW-1:0]            vram_addr,
  input  logic                          vram_ack,
  input  logic [7:0]                    vram_rdata,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [SHADE_W-1:0]            pix_data,
  output logic [7:0]                    pix_x,
  output logic                          renderComplete
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAP   = 3'd1;
  localparam logic [2:0] S_PLANE = 3'd2;
  localparam logic [2:0] S_PUSH  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [7:0]         sx_q, sx_d, sy_q, sy_d, ly_q, ly_d;
  logic [7:0]         tcol_q, tcol_d, tile_q, tile_d, pix_x_q, pix_x_d;
  logic [2:0]         fine_q, fine_d, plane_q, plane_d;
  logic [8:0]         queued_q, queued_d;
  logic [7:0]         planes_q [BPP];
  logic [7:0]         planes_d [BPP];
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]        count_q, count_d;
  logic [SHADE_W-1:0] mem [FIFO_DEPTH];

`ifdef WHIZ_WINDOW_EN
  logic               win_act_q, win_act_d, wmode_q, wmode_d;
  logic [7:0]         win_start_q, win_start_d, wrow_q, wrow_d;
  logic [VRAM_AW-1:0] wmap_q, wmap_d;
`endif

  logic [7:0]         row, col;
  logic [VRAM_AW-1:0] base, map_addr, plane_addr;
  logic [8:0]         limit, remaining;
  logic               push_ok, pop;
  logic [3:0]         n_push;
  logic [BPP-1:0]     colour;
  logic [7:0]         wr_en;
  logic [PW-1:0]      wr_idx [8];
  logic [SHADE_W-1:0] wr_val [8];

  assign pix_valid      = (count_q != '0);
  assign pop            = pix_valid && pix_ready;
  assign pix_data       = pix_valid ? mem[rptr_q] : '0;
  assign pix_x          = pix_x_q;
  assign renderComplete = (state_q == S_DONE);
  assign vram_req       = (state_q == S_MAP) || (state_q == S_PLANE);
  assign vram_addr      = (state_q == S_MAP) ? map_addr : ((state_q == S_PLANE) ? plane_addr : '0);

  always_comb begin
    row   = ly_q + sy_q;
    col   = (sx_q >> 3) + tcol_q;
    base  = map_base;
    limit = 9'(LINE_W);
`ifdef WHIZ_WINDOW_EN
    if (wmode_q) begin
      row  = wrow_q;
      col  = tcol_q;
      base = wmap_q;
    end else if (win_act_q && ({1'b0, win_start_q} < 9'(LINE_W))) begin
      limit = {1'b0, win_start_q};
    end
`endif
    map_addr   = base + VRAM_AW'((row >> 3) & 8'(MAP_DIM - 1)) * VRAM_AW'(MAP_DIM)
               + VRAM_AW'(col & 8'(MAP_DIM - 1));
    plane_addr = tile_base + VRAM_AW'(tile_q) * VRAM_AW'(8 * BPP)
               + VRAM_AW'(row[2:0]) * VRAM_AW'(BPP) + VRAM_AW'(plane_q);

    // Eight pixels land in one cycle; the kept run starts after the fine-scroll skip and stops at the limit.
    push_ok   = (state_q == S_PUSH) && (int'(count_q) <= FIFO_DEPTH - 8);
    remaining = limit - queued_q;
    n_push    = '0;
    colour    = '0;
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < BPP; p++) colour[p] = planes_q[p][7-b];
      wr_en[b]  = push_ok && (4'(b) >= {1'b0, fine_q}) && ((9'(b) - 9'(fine_q)) < remaining);
      wr_idx[b] = wptr_q + PW'(b) - PW'(fine_q);
      wr_val[b] = palette[colour*SHADE_W +: SHADE_W];
      n_push    = n_push + 4'(wr_en[b]);
    end
  end

  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    ly_d     = ly_q;
    tcol_d   = tcol_q;
    tile_d   = tile_q;
    fine_d   = fine_q;
    plane_d  = plane_q;
    queued_d = queued_q;
    planes_d = planes_q;
    pix_x_d  = pop ? pix_x_q + 8'd1 : pix_x_q;
    wptr_d   = wptr_q + PW'(n_push);
    rptr_d   = pop ? rptr_q + PW'(1) : rptr_q;
    count_d  = count_q + (PW+1)'(n_push) - (PW+1)'(pop);
`ifdef WHIZ_WINDOW_EN
    win_act_d   = win_act_q;
    wmode_d     = wmode_q;
    win_start_d = win_start_q;
    wrow_d      = wrow_q;
    wmap_d      = wmap_q;
`endif
    case (state_q)
      S_IDLE: if (drawline) begin
        sx_d     = scroll_x;
        sy_d     = scroll_y;
        ly_d     = line_y;
        tcol_d   = '0;
        fine_d   = scroll_x[2:0];
        queued_d = '0;
        pix_x_d  = '0;
        state_d  = S_MAP;
`ifdef WHIZ_WINDOW_EN
        win_act_d   = win_en && (line_y >= win_y);
        win_start_d = (win_x >= 8'd7) ? win_x - 8'd7 : 8'd0;
        wrow_d      = line_y - win_y;
        wmap_d      = win_map_base;
        wmode_d     = win_act_d && (win_start_d == 8'd0);
        if (wmode_d) fine_d = '0;
`endif
      end
      S_MAP: if (vram_ack) begin
        tile_d  = vram_rdata;
        plane_d = '0;
        state_d = S_PLANE;
      end
      S_PLANE: if (vram_ack) begin
        for (int p = 0; p < BPP; p++)
          if (plane_q == 3'(p)) planes_d[p] = vram_rdata;
        plane_d = plane_q + 3'd1;
        if (plane_q == 3'(BPP - 1)) state_d = S_PUSH;
      end
      S_PUSH: if (push_ok) begin
        queued_d = queued_q + 9'(n_push);
        tcol_d   = tcol_q + 8'd1;
        fine_d   = '0;
        if (queued_d >= 9'(LINE_W)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_MAP;
`ifdef WHIZ_WINDOW_EN
          // Background stops at the window edge; the window restarts from its own column 0.
          if (!wmode_q && win_act_q && (queued_d >= limit)) begin
            wmode_d = 1'b1;
            tcol_d  = '0;
          end
`endif
        end
      end
      S_DRAIN: if (count_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sx_q     <= '0;
      sy_q     <= '0;
      ly_q     <= '0;
      tcol_q   <= '0;
      tile_q   <= '0;
      fine_q   <= '0;
      plane_q  <= '0;
      queued_q <= '0;
      pix_x_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      for (int p = 0; p < BPP; p++) planes_q[p] <= '0;
`ifdef WHIZ_WINDOW_EN
      win_act_q   <= 1'b0;
      wmode_q     <= 1'b0;
      win_start_q <= '0;
      wrow_q      <= '0;
      wmap_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      ly_q     <= ly_d;
      tcol_q   <= tcol_d;
      tile_q   <= tile_d;
      fine_q   <= fine_d;
      plane_q  <= plane_d;
      queued_q <= queued_d;
      pix_x_q  <= pix_x_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      planes_q <= planes_d;
`ifdef WHIZ_WINDOW_EN
      win_act_q   <= win_act_d;
      wmode_q     <= wmode_d;
      win_start_q <= win_start_d;
      wrow_q      <= wrow_d;
      wmap_q      <= wmap_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (wr_en[b]) mem[wr_idx[b]] <= wr_val[b];
  end

endmodule

// File: tb/tb_whiz_line_renderer.sv
// Randomized bench for whiz_line_renderer: VRAM responder with variable latency, throttled consumer,
// and a per-pixel reference model computed directly from scroll/map/tile arithmetic.
module tb_whiz_line_renderer;

  localparam int LINE_W     = 160;
  localparam int MAP_DIM    = 32;
  localparam int BPP        = 2;
  localparam int SHADE_W    = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int VRAM_AW    = 13;
  localparam int VRAM_SIZE  = 1 << VRAM_AW;
  localparam int MAP_BASE   = 'h1800;
  localparam int TILE_BASE  = 'h0000;

  logic               clk;
  logic               reset;
  logic               drawline;
  logic [7:0]         line_y, scroll_x, scroll_y;
  logic [7:0]         palette;
  logic               vram_req;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_ack;
  logic [7:0]         vram_rdata;
  logic               pix_valid;
  logic               pix_ready;
  logic [1:0]         pix_data;
  logic [7:0]         pix_x;
  logic               renderComplete;

  logic [7:0] vram [VRAM_SIZE];
  logic [1:0] exp_pix [LINE_W];
  logic [1:0] got_pix [LINE_W];
  logic [7:0] cur_sx, cur_sy, cur_ly, cur_pal;
  int num_checks = 0;
  int num_errors = 0;
  int ack_lat    = 1;
  int map_reads  = 0;

  whiz_line_renderer #(
    .LINE_W(LINE_W), .MAP_DIM(MAP_DIM), .BPP(BPP), .SHADE_W(SHADE_W),
    .FIFO_DEPTH(FIFO_DEPTH), .VRAM_AW(VRAM_AW)
  ) dut (
    .clk(clk), .reset(reset), .drawline(drawline), .line_y(line_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .palette(palette),
    .map_base(13'(MAP_BASE)), .tile_base(13'(TILE_BASE)),
`ifdef WHIZ_WINDOW_EN
    .win_en(1'b0), .win_x(8'd0), .win_y(8'd0), .win_map_base(13'd0),
`endif
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x),
    .renderComplete(renderComplete)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // VRAM responder: acks a held request ack_lat cycles after it appears, one request at a time.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    vram_ack   = 1'b0;
    vram_rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        vram_ack = 1'b0;
        wait_cnt = 0;
      end else if (vram_ack) begin
        vram_ack = 1'b0;
      end else if (vram_req) begin
        if (wait_cnt >= ack_lat - 1) begin
          vram_ack   = 1'b1;
          vram_rdata = vram[vram_addr];
          wait_cnt   = 0;
          if (int'(vram_addr) >= MAP_BASE && int'(vram_addr) < MAP_BASE + MAP_DIM*MAP_DIM)
            map_reads++;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    num_checks++;
    if (got !== expv) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  // Pixel x of the line sits at absolute background column scroll_x + x.
  function automatic logic [1:0] model_pixel(input int x);
    int ax, row, col, bitp, tile, colour;
    logic [7:0] plane_byte;
    ax     = int'(cur_sx) + x;
    row    = (int'(cur_ly) + int'(cur_sy)) % 256;
    col    = (ax / 8) % MAP_DIM;
    bitp   = ax % 8;
    tile   = int'(vram[(MAP_BASE + (row / 8) * MAP_DIM + col) % VRAM_SIZE]);
    colour = 0;
    for (int p = 0; p < BPP; p++) begin
      plane_byte = vram[(TILE_BASE + tile * 8 * BPP + (row % 8) * BPP + p) % VRAM_SIZE];
      if (plane_byte[7 - bitp]) colour += (1 << p);
    end
    return cur_pal[colour*SHADE_W +: SHADE_W];
  endfunction

  task automatic applyStimulus(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] ly);
    @(negedge clk);
    scroll_x = sx;
    scroll_y = sy;
    line_y   = ly;
    drawline = 1'b1;
    @(negedge clk);
    drawline = 1'b0;
  endtask

  // Renders one line and checks every accepted pixel; abort_at>0 returns early after that many pixels.
  task automatic runLine(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] ly,
                         input int lat, input int ready_mode, input int abort_at);
    int idx, cyc, map0;
    logic stalled, done, saw_rc, rdy;
    logic [1:0] held;
    cur_sx = sx;
    cur_sy = sy;
    cur_ly = ly;
    cur_pal = palette;
    for (int x = 0; x < LINE_W; x++) exp_pix[x] = model_pixel(x);
    ack_lat = lat;
    map0    = map_reads;
    applyStimulus(sx, sy, ly);
    idx = 0; cyc = 0; stalled = 1'b0; held = 2'd0; done = 1'b0; saw_rc = 1'b0;
    while (!done && cyc < 6000) begin
      if (stalled)
        checkOutput("hold_under_stall", {29'd0, pix_valid, pix_data}, {29'd0, 1'b1, held});
      if (renderComplete) begin
        checkOutput("rc_after_all_pixels", idx, LINE_W);
        checkOutput("map_fetches", map_reads - map0, (LINE_W + int'(sx & 8'd7) + 7) / 8);
        saw_rc = 1'b1;
        done   = 1'b1;
      end else begin
        if (cyc == 30) begin
          drawline = 1'b1;
          scroll_x = sx + 8'd5;
          line_y   = ly + 8'd1;
        end else begin
          drawline = 1'b0;
          scroll_x = sx;
          line_y   = ly;
        end
        rdy = (ready_mode == 0) || (cyc % 3 == 0);
        pix_ready = rdy;
        if (pix_valid && rdy) begin
          if (idx < LINE_W) begin
            checkOutput("pix_data", pix_data, exp_pix[idx]);
            got_pix[idx] = pix_data;
          end else begin
            checkOutput("extra_pixel", idx, LINE_W - 1);
          end
          checkOutput("pix_x", pix_x, idx);
          idx++;
        end
        stalled = pix_valid && !rdy;
        held    = pix_data;
        if (abort_at > 0 && idx >= abort_at) begin
          done = 1'b1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    drawline = 1'b0;
    if (!done) begin
      checkOutput("line_timeout", 1, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end else if (saw_rc) begin
      @(negedge clk);
      checkOutput("rc_single_cycle", renderComplete, 0);
    end
  endtask

  initial begin
    logic [1:0] golden [8];
    int seen;
    golden = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
    reset = 1'b1; drawline = 1'b0; line_y = 8'd0; scroll_x = 8'd0; scroll_y = 8'd0;
    palette = 8'hE4; pix_ready = 1'b1;
    for (int i = 0; i < VRAM_SIZE; i++) vram[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    checkOutput("reset_vram_req", vram_req, 0);
    checkOutput("reset_pix_valid", pix_valid, 0);
    checkOutput("reset_rc", renderComplete, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_pix_x", pix_x, 0);
    checkOutput("idle_pix_data", pix_data, 0);
    checkOutput("idle_vram_addr", vram_addr, 0);

    $display("[TB] golden tile line");
    for (int i = 0; i < MAP_DIM*MAP_DIM; i++) vram[MAP_BASE + i] = 8'd0;
    for (int r = 0; r < 8; r++) begin
      vram[TILE_BASE + r*2]     = 8'h0F;
      vram[TILE_BASE + r*2 + 1] = 8'h33;
    end
    runLine(8'd0, 8'd0, 8'd0, 1, 0, 0);
    for (int i = 0; i < 8; i++) checkOutput("golden_first8", got_pix[i], golden[i]);

    for (int i = 0; i < VRAM_SIZE; i++) vram[i] = 8'($urandom);

    $display("[TB] scroll boundary lines");
    palette = 8'($urandom);
    runLine(8'd3, 8'd0, 8'd20, 1, 0, 0);
    palette = 8'($urandom);
    runLine(8'd0, 8'd250, 8'd10, 2, 0, 0);
    palette = 8'($urandom);
    runLine(8'd248, 8'd7, 8'd100, 1, 0, 0);
    palette = 8'($urandom);
    runLine(8'($urandom), 8'($urandom), 8'($urandom), 5, 1, 0);

    $display("[TB] mid-line reset");
    palette = 8'($urandom);
    runLine(8'd17, 8'd3, 8'd60, 3, 1, 40);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_vram_req", vram_req, 0);
    checkOutput("abort_pix_valid", pix_valid, 0);
    checkOutput("abort_pix_x", pix_x, 0);
    checkOutput("abort_pix_data", pix_data, 0);
    checkOutput("abort_rc", renderComplete, 0);
    @(negedge clk);
    reset = 1'b0;
    pix_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (renderComplete) seen++;
    end
    checkOutput("abort_no_rc", seen, 0);
    runLine(8'd17, 8'd3, 8'd60, 1, 0, 0);

    $display("[TB] random lines");
    for (int n = 0; n < 5; n++) begin
      palette = 8'($urandom);
      runLine(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
